// File: rtl/fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Purpose:
//   Redirects the fetch stage when a taken branch resolves in EX or an
//   unconditional jump decodes in ID. The selected target is captured, held
//   while instruction memory is busy, and issued to the PC for one cycle with
//   jump_cs. The wrong-path pipeline registers are then squashed for FLUSH_LEN
//   cycles. The block also produces the fetch stall signal.
//
// Parameters:
//   FLUSH_LEN    cycles the flush outputs stay high, counting the issue cycle
//                (range 1..7)
//
// Optional feature macro:
//   REDIRECT_PERF_EN  when defined, redirect_cnt and stall_cnt are live
//                     32-bit wrapping counters; otherwise both read 0 and
//                     no counter flops exist.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   imem_busy    in   instruction memory not ready, so fetch must hold
//   load_use_hz  in   load-use hazard detected in ID
//   br_valid     in   conditional branch resolved in EX this cycle
//   br_taken     in   branch outcome, meaningful with br_valid
//   br_target    in   32-bit word-address branch target (EX)
//   j_valid      in   unconditional jump decoded in ID this cycle
//   j_target     in   32-bit word-address jump target (ID)
//   stall        out  PC hold (combinational)
//   jump_cs      out  PC load strobe for Next_pc
//   Next_pc      out  redirect target (last captured target)
//   flush_if_id  out  squash IF/ID
//   flush_id_ex  out  squash ID/EX (EX-source redirects only)
//   redirect_cnt out  redirects issued
//   stall_cnt    out  cycles with stall high
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl #(
  parameter int unsigned FLUSH_LEN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_busy,
  input  logic        load_use_hz,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_valid,
  input  logic [31:0] j_target,
  output logic        stall,
  output logic        jump_cs,
  output logic [31:0] Next_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    ISSUE = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // Flush cycles that follow the issue cycle.
  localparam logic [2:0] FLUSH_EXTRA = 3'(FLUSH_LEN - 1);

  state_e      state_q, state_d;
  logic        src_ex_q, src_ex_d;
  logic [31:0] tgt_q, tgt_d;
  logic [2:0]  flush_left_q, flush_left_d;
  logic        jump_q, jump_d;
  logic        fif_q, fif_d;
  logic        fex_q, fex_d;

  logic        req_ex_s;
  logic        req_s;
  logic [31:0] req_tgt_s;
  logic        issue_ex_s;

  // EX wins over ID; a not-taken branch is not a request.
  assign req_ex_s  = br_valid & br_taken;
  assign req_s     = req_ex_s | j_valid;
  assign req_tgt_s = req_ex_s ? br_target : j_target;

  // An issuing EX redirect kills the instruction behind the load, so the
  // load-use stall must not block it.
  assign issue_ex_s = (state_q == ISSUE) & src_ex_q;
  assign stall      = imem_busy | (load_use_hz & ~issue_ex_s);

  // State, captured redirect and flush counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_ex_q     <= 1'b0;
      tgt_q        <= 32'd0;
      flush_left_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      src_ex_q     <= src_ex_d;
      tgt_q        <= tgt_d;
      flush_left_q <= flush_left_d;
    end
  end

  // Next-state logic: capture in IDLE only; requests in other states are
  // wrong-path and ignored.
  always_comb begin
    state_d      = state_q;
    src_ex_d     = src_ex_q;
    tgt_d        = tgt_q;
    flush_left_d = flush_left_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          tgt_d    = req_tgt_s;
          src_ex_d = req_ex_s;
          state_d  = imem_busy ? HOLD : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!imem_busy) begin
          state_d = ISSUE;
        end else begin
          state_d = HOLD;
        end
      end
      ISSUE: begin
        // The PC ignores jump_cs under stall, so a stalled issue cycle is
        // retried from HOLD instead of losing the redirect.
        if (stall) begin
          state_d = HOLD;
        end else if (FLUSH_EXTRA != 3'd0) begin
          state_d      = FLUSH;
          flush_left_d = FLUSH_EXTRA;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (flush_left_q <= 3'd1) begin
          state_d      = IDLE;
          flush_left_d = 3'd0;
        end else begin
          state_d      = FLUSH;
          flush_left_d = flush_left_q - 3'd1;
        end
      end
      default: begin
        state_d      = IDLE;
        flush_left_d = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    jump_d = (state_d == ISSUE);
    fif_d  = (state_d == ISSUE) | (state_d == FLUSH);
    fex_d  = fif_d & src_ex_d;
  end

  // Registered PC-control and flush outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_q <= 1'b0;
      fif_q  <= 1'b0;
      fex_q  <= 1'b0;
    end else begin
      jump_q <= jump_d;
      fif_q  <= fif_d;
      fex_q  <= fex_d;
    end
  end

  // The registered strobe is qualified by stall so the PC never sees
  // jump_cs while held.
  assign jump_cs     = jump_q & ~stall;
  assign Next_pc     = tgt_q;
  assign flush_if_id = fif_q;
  assign flush_id_ex = fex_q;

`ifdef REDIRECT_PERF_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters; both wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      if (jump_cs) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end else begin
        redirect_cnt_q <= redirect_cnt_q;
      end
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = 32'd0;
  assign stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
//
// Purpose: self-checking bench for fetch_redirect_ctrl. Directed scenarios
// plus a randomized run compared against a behavioural redirect model.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;

  localparam int FLEN = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_busy;
  logic        load_use_hz;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        j_valid;
  logic [31:0] j_target;
  logic        stall;
  logic        jump_cs;
  logic [31:0] Next_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;

  int vec;
  int err;

  fetch_redirect_ctrl #(.FLUSH_LEN(FLEN)) dut (
    .clk(clk), .rst_n(rst_n), .imem_busy(imem_busy), .load_use_hz(load_use_hz),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .j_valid(j_valid), .j_target(j_target), .stall(stall), .jump_cs(jump_cs),
    .Next_pc(Next_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic ib, input logic lu, input logic bv, input logic bt,
                       input logic [31:0] btg, input logic jv, input logic [31:0] jt);
    imem_busy   = ib;
    load_use_hz = lu;
    br_valid    = bv;
    br_taken    = bt;
    br_target   = btg;
    j_valid     = jv;
    j_target    = jt;
  endtask

  // One cycle: new inputs at the falling edge, outputs settled 1 ns later.
  task automatic cyc(input logic ib, input logic lu, input logic bv, input logic bt,
                     input logic [31:0] btg, input logic jv, input logic [31:0] jt);
    @(negedge clk);
    drive(ib, lu, bv, bt, btg, jv, jt);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    vec++; if (stall !== 1'b1) begin err++; $display("FAIL rst_stall_busy: got %0b want 1", stall); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    vec++; if (stall !== 1'b1) begin err++; $display("FAIL rst_stall_lu: got %0b want 1", stall); end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234, 1'b0, 32'd0);
    @(negedge clk); #1;
    vec++; if (stall !== 1'b0) begin err++; $display("FAIL rst_stall_idle: got %0b want 0", stall); end
    vec++; if (jump_cs !== 1'b0) begin err++; $display("FAIL rst_jump: got %0b want 0", jump_cs); end
    vec++; if (Next_pc !== 32'd0) begin err++; $display("FAIL rst_pc: got %0h want 0", Next_pc); end
    vec++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin err++; $display("FAIL rst_flush: got %b want 00", {flush_if_id, flush_id_ex}); end
    vec++; if ({redirect_cnt, stall_cnt} !== 64'd0) begin err++; $display("FAIL rst_cnt: got %0h/%0h want 0/0", redirect_cnt, stall_cnt); end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_branch();
    apply_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if (jump_cs !== 1'b1) begin err++; $display("FAIL br_n1_jump: got %0b want 1", jump_cs); end
    vec++; if (Next_pc !== 32'h40) begin err++; $display("FAIL br_n1_pc: got %0h want 40", Next_pc); end
    vec++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin err++; $display("FAIL br_n1_flush: got %b want 11", {flush_if_id, flush_id_ex}); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if (jump_cs !== 1'b0) begin err++; $display("FAIL br_n2_jump: got %0b want 0", jump_cs); end
    vec++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin err++; $display("FAIL br_n2_flush: got %b want 11", {flush_if_id, flush_id_ex}); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if ({jump_cs, flush_if_id, flush_id_ex} !== 3'b000) begin err++; $display("FAIL br_n3_low: got %b want 000", {jump_cs, flush_if_id, flush_id_ex}); end
    vec++; if (Next_pc !== 32'h40) begin err++; $display("FAIL br_n3_pc_hold: got %0h want 40", Next_pc); end
    // Not-taken branch is ignored.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h99, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if ({jump_cs, flush_if_id} !== 2'b00) begin err++; $display("FAIL br_not_taken: got %b want 00", {jump_cs, flush_if_id}); end
    vec++; if (Next_pc !== 32'h40) begin err++; $display("FAIL br_not_taken_pc: got %0h want 40", Next_pc); end
  endtask

  task automatic test_priority();
    apply_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if (jump_cs !== 1'b1) begin err++; $display("FAIL prio_jump: got %0b want 1", jump_cs); end
    vec++; if (Next_pc !== 32'h20) begin err++; $display("FAIL prio_pc: got %0h want 20", Next_pc); end
    vec++; if (flush_id_ex !== 1'b1) begin err++; $display("FAIL prio_fex: got %0b want 1", flush_id_ex); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      vec++; if (jump_cs !== 1'b0 || Next_pc !== 32'h20) begin err++; $display("FAIL prio_single[%0d]: got %0b/%0h want 0/20", i, jump_cs, Next_pc); end
    end
  endtask

  task automatic test_imem_hold();
    apply_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      vec++; if ({stall, jump_cs} !== 2'b10) begin err++; $display("FAIL hold_busy[%0d]: got %b want 10", i, {stall, jump_cs}); end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if ({stall, jump_cs} !== 2'b00) begin err++; $display("FAIL hold_release: got %b want 00", {stall, jump_cs}); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if (jump_cs !== 1'b1) begin err++; $display("FAIL hold_issue_jump: got %0b want 1", jump_cs); end
    vec++; if (Next_pc !== 32'h80) begin err++; $display("FAIL hold_issue_pc: got %0h want 80", Next_pc); end
  endtask

  task automatic test_load_use();
    logic seen;
    apply_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if ({stall, jump_cs} !== 2'b01) begin err++; $display("FAIL lu_ex_issue: got %b want 01", {stall, jump_cs}); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h200);
    vec++; if ({jump_cs, flush_if_id} !== 2'b01) begin err++; $display("FAIL lu_flush_j: got %b want 01", {jump_cs, flush_if_id}); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      vec++; if (jump_cs !== 1'b0 || Next_pc !== 32'h100) begin err++; $display("FAIL lu_no_second[%0d]: got %0b/%0h want 0/100", i, jump_cs, Next_pc); end
    end
    // ID-source issue under load-use: PC is held, so jump_cs must stay low.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h300);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if ({stall, jump_cs, flush_id_ex} !== 3'b100) begin err++; $display("FAIL lu_id_issue: got %b want 100", {stall, jump_cs, flush_id_ex}); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      if (jump_cs === 1'b1 && Next_pc === 32'h300) seen = 1'b1;
    end
    vec++; if (seen !== 1'b1) begin err++; $display("FAIL lu_id_retry: got %0b want 1", seen); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    vec++; if (Next_pc !== 32'h55) begin err++; $display("FAIL ar_hold_pc: got %0h want 55", Next_pc); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if ({jump_cs, flush_if_id, flush_id_ex} !== 3'b000 || Next_pc !== 32'd0) begin err++; $display("FAIL ar_hold_out: got %b/%0h want 000/0", {jump_cs, flush_if_id, flush_id_ex}, Next_pc); end
    vec++; if (stall !== 1'b1) begin err++; $display("FAIL ar_stall: got %0b want 1", stall); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      vec++; if ({jump_cs, flush_if_id} !== 2'b00) begin err++; $display("FAIL ar_idle[%0d]: got %b want 00", i, {jump_cs, flush_if_id}); end
    end
    // Reset during the issue cycle drops the flushes at once.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h77, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    vec++; if ({jump_cs, flush_if_id, flush_id_ex} !== 3'b000) begin err++; $display("FAIL ar_issue_out: got %b want 000", {jump_cs, flush_if_id, flush_id_ex}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_counters();
    apply_reset();
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int r = 0; r < 3; r++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'(r * 4), 1'b0, 32'd0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    end
`ifdef REDIRECT_PERF_EN
    vec++; if (redirect_cnt !== 32'd3) begin err++; $display("FAIL cnt_redirect: got %0d want 3", redirect_cnt); end
    vec++; if (stall_cnt !== 32'd4) begin err++; $display("FAIL cnt_stall: got %0d want 4", stall_cnt); end
`else
    vec++; if (redirect_cnt !== 32'd0) begin err++; $display("FAIL cnt_redirect_off: got %0d want 0", redirect_cnt); end
    vec++; if (stall_cnt !== 32'd0) begin err++; $display("FAIL cnt_stall_off: got %0d want 0", stall_cnt); end
`endif
  endtask

  // Randomized run against a redirect model: a captured redirect is either
  // pending (waiting for memory), being issued, or draining its flush window.
  task automatic test_random();
    logic        pend, issuing, ex;
    int          fl;
    logic [31:0] tgt;
    int          n_redir, n_stall;
    logic        e_stall, e_jump, e_fif, e_fex;
    logic [31:0] e_rc, e_sc;
    apply_reset();
    pend = 1'b0; issuing = 1'b0; ex = 1'b0; fl = 0; tgt = 32'd0;
    n_redir = 0; n_stall = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 4) == 0), $urandom);
      e_stall = imem_busy | (load_use_hz & ~(issuing & ex));
      e_jump  = issuing & ~e_stall;
      e_fif   = issuing | (fl != 0);
      e_fex   = e_fif & ex;
`ifdef REDIRECT_PERF_EN
      e_rc = 32'(n_redir);
      e_sc = 32'(n_stall);
`else
      e_rc = 32'd0;
      e_sc = 32'd0;
`endif
      vec++; if (stall !== e_stall) begin err++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", i, stall, e_stall); end
      vec++; if (jump_cs !== e_jump) begin err++; $display("FAIL rnd_jump[%0d]: got %0b want %0b", i, jump_cs, e_jump); end
      vec++; if (Next_pc !== tgt) begin err++; $display("FAIL rnd_pc[%0d]: got %0h want %0h", i, Next_pc, tgt); end
      vec++; if ({flush_if_id, flush_id_ex} !== {e_fif, e_fex}) begin err++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, {flush_if_id, flush_id_ex}, {e_fif, e_fex}); end
      vec++; if ({redirect_cnt, stall_cnt} !== {e_rc, e_sc}) begin err++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, redirect_cnt, stall_cnt, e_rc, e_sc); end
      // Model advance for the coming rising edge.
      if (e_stall) n_stall++;
      if (e_jump) n_redir++;
      if (issuing) begin
        issuing = 1'b0;
        if (e_stall) pend = 1'b1;
        else fl = FLEN - 1;
      end else if (pend) begin
        if (!imem_busy) begin
          pend = 1'b0;
          issuing = 1'b1;
        end
      end else if (fl != 0) begin
        fl--;
      end else if ((br_valid & br_taken) | j_valid) begin
        ex  = br_valid & br_taken;
        tgt = ex ? br_target : j_target;
        if (imem_busy) pend = 1'b1;
        else issuing = 1'b1;
      end
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    test_reset();
    test_branch();
    test_priority();
    test_imem_hold();
    test_load_use();
    test_async_reset();
    test_counters();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
